// File: rtl/knn_sorted_core_if.sv
// Handshake and result bundle for knn_sorted_core: test point / data-point
// stream in, sorted neighbour list and vote result out.
interface knn_sorted_core_if #(
  parameter int unsigned K       = 4,
  parameter int unsigned DIM     = 2,
  parameter int unsigned COORD_W = 8,
  parameter int unsigned LABEL_W = 4
);
  localparam int unsigned DIST_W = 2*COORD_W + 1 + $clog2(DIM);
  localparam int unsigned ENT_W  = DIST_W + LABEL_W;
  localparam int unsigned CNT_W  = $clog2(K+1);

  logic                     start;
  logic [DIM*COORD_W-1:0]   test_point;
  logic                     dp_valid;
  logic                     dp_ready;
  logic [DIM*COORD_W-1:0]   dp_coord;
  logic [LABEL_W-1:0]       dp_label;
  logic                     dp_last;
  logic [K*ENT_W-1:0]       nb_list;
  logic [CNT_W-1:0]         nb_count;
  logic [LABEL_W-1:0]       class_label;
  logic                     busy;
  logic                     done;

  modport master (
    output start, test_point, dp_valid, dp_coord, dp_label, dp_last,
    input  dp_ready, nb_list, nb_count, class_label, busy, done
  );

  modport slave (
    input  start, test_point, dp_valid, dp_coord, dp_label, dp_last,
    output dp_ready, nb_list, nb_count, class_label, busy, done
  );
endinterface

// File: rtl/knn_sorted_core.sv
// K-nearest-neighbour core: 3-stage squared-distance pipeline feeding a
// distance-sorted K-entry list, followed by a sequential majority vote.
module knn_sorted_core #(
  parameter int unsigned K       = 4,
  parameter int unsigned DIM     = 2,
  parameter int unsigned COORD_W = 8,
  parameter int unsigned LABEL_W = 4
) (
  input logic              clk,
  input logic              rst_n,
  knn_sorted_core_if.slave bus
);
  localparam int unsigned DIST_W = 2*COORD_W + 1 + $clog2(DIM);
  localparam int unsigned ENT_W  = DIST_W + LABEL_W;
  localparam int unsigned DIFF_W = COORD_W + 1;
  localparam int unsigned PROD_W = 2*DIFF_W;
  localparam int unsigned SQ_W   = 2*COORD_W;
  localparam int unsigned CNT_W  = $clog2(K+1);
  localparam int unsigned IDX_W  = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned TP_W   = DIM*COORD_W;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_VOTE, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [TP_W-1:0]     tp_q, tp_d;
  logic                s1_vld_q, s1_vld_d;
  logic [SQ_W-1:0]     s1_sq_q [DIM];
  logic [SQ_W-1:0]     s1_sq_d [DIM];
  logic [LABEL_W-1:0]  s1_lab_q, s1_lab_d;
  logic                s2_vld_q, s2_vld_d;
  logic [DIST_W-1:0]   s2_dist_q, s2_dist_d;
  logic [LABEL_W-1:0]  s2_lab_q, s2_lab_d;
  logic [DIST_W-1:0]   dist_q [K];
  logic [DIST_W-1:0]   dist_d [K];
  logic [LABEL_W-1:0]  lab_q [K];
  logic [LABEL_W-1:0]  lab_d [K];
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          drain_q, drain_d;
  logic [IDX_W-1:0]    vidx_q, vidx_d;
  logic [CNT_W-1:0]    best_cnt_q, best_cnt_d;
  logic [LABEL_W-1:0]  best_lab_q, best_lab_d;
  logic [LABEL_W-1:0]  class_q, class_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                       beat;
  logic signed [DIFF_W-1:0]   diff;
  logic signed [PROD_W-1:0]   prod;
  logic [DIST_W-1:0]          sum;
  logic [K-1:0]               gt;
  logic [K-1:0]               gt_prev;
  logic [CNT_W-1:0]           match;
  logic [CNT_W-1:0]           best_cnt_nx;
  logic [LABEL_W-1:0]         best_lab_nx;

  always_comb begin
    state_d    = state_q;
    tp_d       = tp_q;
    s1_lab_d   = s1_lab_q;
    s2_vld_d   = s1_vld_q;
    s2_dist_d  = s2_dist_q;
    s2_lab_d   = s1_lab_q;
    cnt_d      = cnt_q;
    drain_d    = drain_q;
    vidx_d     = vidx_q;
    best_cnt_d = best_cnt_q;
    best_lab_d = best_lab_q;
    class_d    = class_q;
    for (int unsigned i = 0; i < K; i++) begin
      dist_d[i] = dist_q[i];
      lab_d[i]  = lab_q[i];
    end
    for (int unsigned d = 0; d < DIM; d++) s1_sq_d[d] = s1_sq_q[d];
    diff    = '0;
    prod    = '0;
    sum     = '0;
    gt      = '0;
    gt_prev = '0;
    match   = '0;

    // start takes priority over a beat presented in the same cycle
    beat     = bus.dp_valid && ready_q && !bus.start;
    s1_vld_d = beat;

    // S1: per-dimension squared difference of sign-extended coordinates
    if (beat) begin
      s1_lab_d = bus.dp_label;
      for (int unsigned d = 0; d < DIM; d++) begin
        diff = DIFF_W'($signed(bus.dp_coord[d*COORD_W +: COORD_W]))
             - DIFF_W'($signed(tp_q[d*COORD_W +: COORD_W]));
        prod = PROD_W'(diff) * PROD_W'(diff);
        s1_sq_d[d] = SQ_W'(prod);
      end
    end

    // S2: lossless sum of squares
    for (int unsigned d = 0; d < DIM; d++) sum = sum + DIST_W'(s1_sq_q[d]);
    s2_dist_d = sum;

    // S3: gt is monotone over the sorted valid prefix, so the first set bit is the slot
    for (int unsigned i = 0; i < K; i++)
      gt[i] = (CNT_W'(i) >= cnt_q) || (dist_q[i] > s2_dist_q);
    for (int unsigned i = 1; i < K; i++) gt_prev[i] = gt[i-1];
    if (s2_vld_q) begin
      for (int unsigned i = 0; i < K; i++) begin
        if (gt_prev[i]) begin
          dist_d[i] = dist_q[i-1];
          lab_d[i]  = lab_q[i-1];
        end else if (gt[i]) begin
          dist_d[i] = s2_dist_q;
          lab_d[i]  = s2_lab_q;
        end
      end
      if (gt[K-1] && (cnt_q != CNT_W'(K))) cnt_d = cnt_q + CNT_W'(1);
    end

    // vote step: strict greater keeps the nearer label on ties
    for (int unsigned j = 0; j < K; j++)
      if ((CNT_W'(j) < cnt_q) && (lab_q[j] == lab_q[vidx_q])) match = match + CNT_W'(1);
    best_cnt_nx = best_cnt_q;
    best_lab_nx = best_lab_q;
    if ((CNT_W'(vidx_q) < cnt_q) && (match > best_cnt_q)) begin
      best_cnt_nx = match;
      best_lab_nx = lab_q[vidx_q];
    end

    case (state_q)
      S_IDLE: ;
      S_RUN: begin
        if (beat && bus.dp_last) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end
      end
      S_DRAIN: begin
        drain_d = drain_q + 2'd1;
        if (drain_q == 2'd2) begin
          state_d    = S_VOTE;
          vidx_d     = '0;
          best_cnt_d = '0;
          best_lab_d = '0;
        end
      end
      S_VOTE: begin
        best_cnt_d = best_cnt_nx;
        best_lab_d = best_lab_nx;
        vidx_d     = vidx_q + IDX_W'(1);
        if (vidx_q == IDX_W'(K-1)) begin
          state_d = S_DONE;
          class_d = best_lab_nx;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // start: latch test point, flush pipeline, clear list, (re)enter RUN
    if (bus.start) begin
      state_d    = S_RUN;
      tp_d       = bus.test_point;
      s1_vld_d   = 1'b0;
      s2_vld_d   = 1'b0;
      cnt_d      = '0;
      drain_d    = '0;
      vidx_d     = '0;
      best_cnt_d = '0;
      best_lab_d = '0;
      class_d    = '0;
      for (int unsigned i = 0; i < K; i++) begin
        dist_d[i] = '0;
        lab_d[i]  = '0;
      end
    end

    ready_d = (state_d == S_RUN);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tp_q       <= '0;
      s1_vld_q   <= 1'b0;
      s1_lab_q   <= '0;
      s2_vld_q   <= 1'b0;
      s2_dist_q  <= '0;
      s2_lab_q   <= '0;
      cnt_q      <= '0;
      drain_q    <= '0;
      vidx_q     <= '0;
      best_cnt_q <= '0;
      best_lab_q <= '0;
      class_q    <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int unsigned d = 0; d < DIM; d++) s1_sq_q[d] <= '0;
      for (int unsigned i = 0; i < K; i++) begin
        dist_q[i] <= '0;
        lab_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      tp_q       <= tp_d;
      s1_vld_q   <= s1_vld_d;
      s1_lab_q   <= s1_lab_d;
      s2_vld_q   <= s2_vld_d;
      s2_dist_q  <= s2_dist_d;
      s2_lab_q   <= s2_lab_d;
      cnt_q      <= cnt_d;
      drain_q    <= drain_d;
      vidx_q     <= vidx_d;
      best_cnt_q <= best_cnt_d;
      best_lab_q <= best_lab_d;
      class_q    <= class_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      for (int unsigned d = 0; d < DIM; d++) s1_sq_q[d] <= s1_sq_d[d];
      for (int unsigned i = 0; i < K; i++) begin
        dist_q[i] <= dist_d[i];
        lab_q[i]  <= lab_d[i];
      end
    end
  end

  for (genvar g = 0; g < int'(K); g++) begin : g_list
    assign bus.nb_list[g*ENT_W +: ENT_W] = {dist_q[g], lab_q[g]};
  end

  assign bus.nb_count    = cnt_q;
  assign bus.class_label = class_q;
  assign bus.dp_ready    = ready_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
endmodule

// File: tb/tb_knn_sorted_core.sv
// Self-checking bench for knn_sorted_core: vector table plus a scoreboard
// of expected list states and done/class events.
module tb_knn_sorted_core;
  localparam int unsigned K       = 4;
  localparam int unsigned DIM     = 2;
  localparam int unsigned COORD_W = 8;
  localparam int unsigned LABEL_W = 4;
  localparam int unsigned DIST_W  = 18;
  localparam int unsigned ENT_W   = DIST_W + LABEL_W;
  localparam int unsigned LW      = K*ENT_W;

  typedef struct { int x; int y; int lab; } pt_t;
  typedef struct { int tpx; int tpy; int first; int n; int ecnt; int eclass; logic [LW-1:0] elist; } vec_t;
  typedef struct { int due; int cnt; logic [LW-1:0] lst; } sb_t;

  logic clk;
  logic rst_n;
  knn_sorted_core_if #(.K(K), .DIM(DIM), .COORD_W(COORD_W), .LABEL_W(LABEL_W)) bus();
  knn_sorted_core #(.K(K), .DIM(DIM), .COORD_W(COORD_W), .LABEL_W(LABEL_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int exp_done = -1;
  int exp_class = 0;
  bit saw_done = 0;
  int cur_tpx, cur_tpy;
  int md [K];
  int ml [K];
  int mcnt = 0;
  sb_t sbq [$];
  pt_t pts [21];
  vec_t vecs [6];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s @cyc %0d: got no event, want event within bound", nm, cyc);
  endtask

  function automatic logic [LW-1:0] pk(int d0, int l0, int d1, int l1, int d2, int l2, int d3, int l3);
    logic [LW-1:0] r;
    r = {DIST_W'(d3), LABEL_W'(l3), DIST_W'(d2), LABEL_W'(l2),
         DIST_W'(d1), LABEL_W'(l1), DIST_W'(d0), LABEL_W'(l0)};
    return r;
  endfunction

  function automatic logic [LW-1:0] vmask(int c);
    logic [LW-1:0] r;
    r = '0;
    for (int i = 0; i < c; i++) r[i*ENT_W +: ENT_W] = '1;
    return r;
  endfunction

  function automatic logic [LW-1:0] mpack();
    logic [LW-1:0] r;
    r = '0;
    for (int i = 0; i < mcnt; i++) r[i*ENT_W +: ENT_W] = {DIST_W'(md[i]), LABEL_W'(ml[i])};
    return r;
  endfunction

  // reference list: sorted by distance, ties stay in arrival order
  task automatic m_insert(input int d, input int l);
    int p;
    p = K;
    for (int i = K-1; i >= 0; i--) if (i >= mcnt || md[i] > d) p = i;
    if (p < K) begin
      for (int i = K-1; i > p; i--) begin md[i] = md[i-1]; ml[i] = ml[i-1]; end
      md[p] = d;
      ml[p] = l;
      if (mcnt < K) mcnt++;
    end
  endtask

  function automatic int m_vote();
    int best, bl, c;
    best = 0; bl = 0;
    for (int i = 0; i < mcnt; i++) begin
      c = 0;
      for (int j = 0; j < mcnt; j++) if (ml[j] == ml[i]) c++;
      if (c > best) begin best = c; bl = ml[i]; end
    end
    return bl;
  endfunction

  task automatic m_clear();
    mcnt = 0;
    for (int i = 0; i < K; i++) begin md[i] = 0; ml[i] = 0; end
  endtask

  // one clock: sample #1 after the edge, then score list and done events
  task automatic tick();
    sb_t e;
    @(posedge clk);
    #1;
    cyc++;
    while (sbq.size() > 0 && sbq[0].due < cyc) begin
      e = sbq.pop_front();
      timeout_fail("sb_overdue");
    end
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      chk("sb_count", 128'(bus.nb_count), 128'(e.cnt));
      chk("sb_list", 128'(bus.nb_list & vmask(e.cnt)), 128'(e.lst & vmask(e.cnt)));
    end
    if (bus.done || cyc == exp_done) begin
      chk("done_pulse", 128'(bus.done), 128'(cyc == exp_done));
      if (bus.done && cyc == exp_done) chk("class_model", 128'(bus.class_label), 128'(exp_class));
      if (bus.done) saw_done = 1;
    end
  endtask

  task automatic drive_cycle(output bit acc);
    int dx, dy;
    sb_t e;
    acc = bus.dp_valid && bus.dp_ready && !bus.start;
    if (bus.start) begin
      sbq.delete();
      m_clear();
      exp_done = -1;
      e.due = cyc + 1; e.cnt = 0; e.lst = '0;
      sbq.push_back(e);
    end else if (acc) begin
      dx = int'($signed(bus.dp_coord[7:0])) - cur_tpx;
      dy = int'($signed(bus.dp_coord[15:8])) - cur_tpy;
      m_insert(dx*dx + dy*dy, int'(bus.dp_label));
      e.due = cyc + 3; e.cnt = mcnt; e.lst = mpack();
      sbq.push_back(e);
      if (bus.dp_last) begin
        exp_done  = cyc + 8;
        exp_class = m_vote();
      end
    end
    tick();
  endtask

  task automatic start_pass(input int x, input int y);
    bit a;
    cur_tpx = x;
    cur_tpy = y;
    bus.test_point = {COORD_W'(y), COORD_W'(x)};
    bus.start = 1'b1;
    drive_cycle(a);
    bus.start = 1'b0;
  endtask

  task automatic send_point(input int x, input int y, input int l, input bit last, input int gaps);
    bit a;
    int n;
    bus.dp_valid = 1'b0;
    repeat (gaps) drive_cycle(a);
    bus.dp_coord = {COORD_W'(y), COORD_W'(x)};
    bus.dp_label = LABEL_W'(l);
    bus.dp_last  = last;
    bus.dp_valid = 1'b1;
    a = 0; n = 0;
    while (!a && n < 20) begin drive_cycle(a); n++; end
    if (!a) timeout_fail("accept_timeout");
    bus.dp_valid = 1'b0;
    bus.dp_last  = 1'b0;
  endtask

  task automatic wait_done();
    bit a;
    int n;
    saw_done = 0;
    n = 0;
    while (!saw_done && n < 40) begin drive_cycle(a); n++; end
    if (!saw_done) timeout_fail("done_timeout");
  endtask

  task automatic run_vec(input int v, input bit hold);
    bit a;
    pt_t p;
    start_pass(vecs[v].tpx, vecs[v].tpy);
    for (int i = 0; i < vecs[v].n; i++) begin
      p = pts[vecs[v].first + i];
      send_point(p.x, p.y, p.lab, i == vecs[v].n - 1, (v == 0) ? 0 : int'($urandom_range(0, 1)));
    end
    if (hold) begin
      // a would-be nearest point offered outside RUN must be ignored
      bus.dp_coord = {COORD_W'(vecs[v].tpy), COORD_W'(vecs[v].tpx)};
      bus.dp_label = 4'hF;
      bus.dp_last  = 1'b1;
      bus.dp_valid = 1'b1;
      repeat (4) drive_cycle(a);
      chk("ready_in_vote", 128'(bus.dp_ready), 128'(0));
      chk("busy_in_vote", 128'(bus.busy), 128'(1));
    end
    wait_done();
    chk($sformatf("v%0d_count", v), 128'(bus.nb_count), 128'(vecs[v].ecnt));
    chk($sformatf("v%0d_class", v), 128'(bus.class_label), 128'(vecs[v].eclass));
    chk($sformatf("v%0d_list", v), 128'(bus.nb_list & vmask(vecs[v].ecnt)),
        128'(vecs[v].elist & vmask(vecs[v].ecnt)));
    bus.dp_valid = 1'b0;
    bus.dp_last  = 1'b0;
    drive_cycle(a);
    chk($sformatf("v%0d_idle_busy", v), 128'(bus.busy), 128'(0));
    chk($sformatf("v%0d_class_held", v), 128'(bus.class_label), 128'(vecs[v].eclass));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, 128'(bus.dp_ready), 128'(0));
    chk({tag, "_busy"},  128'(bus.busy), 128'(0));
    chk({tag, "_done"},  128'(bus.done), 128'(0));
    chk({tag, "_count"}, 128'(bus.nb_count), 128'(0));
    chk({tag, "_list"},  128'(bus.nb_list), 128'(0));
    chk({tag, "_class"}, 128'(bus.class_label), 128'(0));
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got simulation still running, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    pts[0]  = '{3, 4, 1};      pts[1]  = '{1, 1, 2};      pts[2]  = '{-2, 0, 3};
    pts[3]  = '{127, 127, 5};
    pts[4]  = '{1, 0, 1};      pts[5]  = '{1, 1, 2};      pts[6]  = '{0, 2, 3};
    pts[7]  = '{2, 1, 4};      pts[8]  = '{-1, 2, 5};     pts[9]  = '{3, 3, 8};
    pts[10] = '{0, 0, 6};
    pts[11] = '{1, 2, 7};      pts[12] = '{2, 1, 9};      pts[13] = '{-1, -2, 9};
    pts[14] = '{-2, -1, 9};
    pts[15] = '{10, -10, 3};   pts[16] = '{11, -10, 4};   pts[17] = '{10, -8, 4};
    pts[18] = '{20, 20, 3};
    pts[19] = '{-128, 127, 15}; pts[20] = '{127, -128, 0};
    vecs[0] = '{0, 0, 0, 3, 3, 2, pk(2, 2, 4, 3, 25, 1, 0, 0)};
    vecs[1] = '{-128, -128, 3, 1, 1, 5, pk(130050, 5, 0, 0, 0, 0, 0, 0)};
    vecs[2] = '{0, 0, 4, 7, 4, 6, pk(0, 6, 1, 1, 2, 2, 4, 3)};
    vecs[3] = '{0, 0, 11, 4, 4, 9, pk(5, 7, 5, 9, 5, 9, 5, 9)};
    vecs[4] = '{10, -10, 15, 4, 4, 3, pk(0, 3, 1, 4, 4, 4, 1000, 3)};
    vecs[5] = '{127, -128, 19, 2, 2, 0, pk(0, 0, 130050, 15, 0, 0, 0, 0)};

    rst_n = 1'b0;
    bus.start = 1'b0; bus.test_point = '0; bus.dp_valid = 1'b0;
    bus.dp_coord = '0; bus.dp_label = '0; bus.dp_last = 1'b0;
    m_clear();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    drive_cycle(a);

    run_vec(0, 1'b1);
    for (int v = 1; v < 6; v++) run_vec(v, 1'b0);

    // abort in RUN with two points in flight; a beat alongside start is dropped
    start_pass(0, 0);
    send_point(1, 0, 1, 1'b0, 0);
    send_point(2, 0, 2, 1'b0, 0);
    bus.dp_coord = {COORD_W'(5), COORD_W'(5)};
    bus.dp_label = 4'd9;
    bus.dp_valid = 1'b1;
    start_pass(5, 5);
    bus.dp_valid = 1'b0;
    for (int i = 0; i < 5; i++) chk("abort_run_count", 128'(bus.nb_count), 128'(0));
    repeat (4) begin
      drive_cycle(a);
      chk("abort_run_count_hold", 128'(bus.nb_count), 128'(0));
    end
    send_point(5, 6, 4, 1'b1, 0);
    wait_done();
    chk("abort_run_class", 128'(bus.class_label), 128'(4));
    chk("abort_run_list", 128'(bus.nb_list & vmask(1)), 128'(pk(1, 4, 0, 0, 0, 0, 0, 0)));

    // abort in VOTE: no done pulse for the aborted pass
    start_pass(0, 0);
    send_point(1, 1, 3, 1'b1, 0);
    repeat (4) drive_cycle(a);
    start_pass(0, 0);
    repeat (10) drive_cycle(a);
    chk("abort_vote_count", 128'(bus.nb_count), 128'(0));
    chk("abort_vote_busy", 128'(bus.busy), 128'(1));
    chk("abort_vote_ready", 128'(bus.dp_ready), 128'(1));
    send_point(0, 1, 6, 1'b1, 0);
    wait_done();
    chk("abort_vote_class", 128'(bus.class_label), 128'(6));

    // asynchronous reset mid-pipeline
    start_pass(0, 0);
    send_point(3, 0, 1, 1'b0, 0);
    rst_n = 1'b0;
    #2;
    check_all_zero("midreset");
    sbq.delete();
    m_clear();
    exp_done = -1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) drive_cycle(a);
    chk("midreset_count_after", 128'(bus.nb_count), 128'(0));
    chk("midreset_busy_after", 128'(bus.busy), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
